// File: rtl/nn_fixed_pkg.sv
// Shared signed fixed-point formats for the sigmoid and neuron blocks.
// Provides Q8.8 / Q16.16 widths, the encoding of 1.0, and the value typedefs.
package nn_fixed_pkg;

  localparam int unsigned Q8_8_BITS   = 16;
  localparam int unsigned Q8_8_FRAC   = 8;
  localparam int unsigned Q16_16_BITS = 32;
  localparam int unsigned Q16_16_FRAC = 16;

  localparam logic [15:0] Q8_8_ONE   = 16'h0100;
  localparam logic [31:0] Q16_16_ONE = 32'h0001_0000;

  typedef logic signed [15:0] q8_8_t;
  typedef logic signed [31:0] q16_16_t;

endpackage

// File: rtl/multiplier_scale.sv
// Combinational rescale of a 2*BITS product: arithmetic shift by FRAC, slice to BITS.
// MULTIPLIER_SATURATE_EN selects clamping on overflow; otherwise the slice wraps.
module multiplier_scale #(
  parameter int unsigned BITS = 16,
  parameter int unsigned FRAC = BITS / 2
) (
  input  logic signed [2*BITS-1:0] p,
  output logic signed [BITS-1:0]   ab
);

`ifdef MULTIPLIER_SATURATE_EN
  logic signed [2*BITS-1:0] shifted;
  logic                     ovf;

  assign shifted = p >>> FRAC;
  // In range only when every bit above the result's sign bit copies it.
  assign ovf = (shifted[2*BITS-1:BITS-1] != '0) && (shifted[2*BITS-1:BITS-1] != '1);

  always_comb begin
    ab = shifted[BITS-1:0];
    if (ovf) begin
      ab = p[2*BITS-1] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
    end
  end
`else
  assign ab = BITS'(p >>> FRAC);
`endif

endmodule

// File: rtl/multiplier.sv
// Three-stage pipelined signed fixed-point multiplier: AB = (A*B) >>> FRAC.
// Overflow policy is wrap by default; define MULTIPLIER_SATURATE_EN to clamp.
module multiplier
  import nn_fixed_pkg::*;
#(
  parameter int unsigned BITS = Q8_8_BITS,
  parameter int unsigned FRAC = BITS / 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  output logic            out_valid,
  output logic [BITS-1:0] AB
);

  logic signed [BITS-1:0]   a_r;
  logic signed [BITS-1:0]   b_r;
  logic signed [2*BITS-1:0] a_x;
  logic signed [2*BITS-1:0] b_x;
  logic signed [2*BITS-1:0] p_r;
  logic signed [BITS-1:0]   scaled;
  logic                     v1;
  logic                     v2;

  assign a_x = $signed({{BITS{a_r[BITS-1]}}, a_r});
  assign b_x = $signed({{BITS{b_r[BITS-1]}}, b_r});

  multiplier_scale #(
    .BITS(BITS),
    .FRAC(FRAC)
  ) u_scale (
    .p (p_r),
    .ab(scaled)
  );

  // Data registers only load on a valid slot so AB holds between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      p_r       <= '0;
      AB        <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (in_valid) begin
        a_r <= A;
        b_r <= B;
      end
      if (v1) begin
        p_r <= a_x * b_x;
      end
      if (v2) begin
        AB <= scaled;
      end
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Bench for multiplier at Q8.8 and Q16.16: queue-based reference model checked every cycle.
module tb_multiplier;

  typedef struct {
    longint ab;
    int     due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv16, ov16, iv32, ov32;
  logic [15:0] a16, b16, ab16;
  logic [31:0] a32, b32, ab32;

  int   edge_cnt = 0;
  int   checks   = 0;
  int   passed   = 0;
  exp_t q16[$];
  exp_t q32[$];
  longint last16 = 0;
  longint last32 = 0;

  multiplier #(.BITS(16), .FRAC(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .A(a16), .B(b16),
    .out_valid(ov16), .AB(ab16)
  );

  multiplier #(.BITS(32), .FRAC(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .A(a32), .B(b32),
    .out_valid(ov32), .AB(ab32)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  function automatic longint model(longint a, longint b, int bits, int frac);
    longint s;
    s = (a * b) >>> frac;
`ifdef MULTIPLIER_SATURATE_EN
    if (s > ((longint'(1) << (bits - 1)) - 1)) s = (longint'(1) << (bits - 1)) - 1;
    else if (s < -(longint'(1) << (bits - 1))) s = -(longint'(1) << (bits - 1));
`endif
    return s & ((longint'(1) << bits) - 1);
  endfunction

  function automatic longint m16(logic [15:0] a, logic [15:0] b);
    return model(longint'($signed(a)), longint'($signed(b)), 16, 8);
  endfunction

  function automatic longint m32(logic [31:0] a, logic [31:0] b);
    return model(longint'($signed(a)), longint'($signed(b)), 32, 16);
  endfunction

  task automatic chk(string name, longint got, longint exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic drive(bit v16, logic [15:0] x16, logic [15:0] y16,
                       bit v32, logic [31:0] x32, logic [31:0] y32);
    iv16 = v16; a16 = x16; b16 = y16;
    iv32 = v32; a32 = x32; b32 = y32;
    if (v16) q16.push_back('{m16(x16, y16), edge_cnt + 3});
    if (v32) q32.push_back('{m32(x32, y32), edge_cnt + 3});
  endtask

  task automatic cyc(bit v16, logic [15:0] x16, logic [15:0] y16,
                     bit v32, logic [31:0] x32, logic [31:0] y32);
    @(negedge clk);
    drive(v16, x16, y16, v32, x32, y32);
  endtask

  task automatic idle();
    cyc(1'b0, 16'($urandom), 16'($urandom), 1'b0, $urandom, $urandom);
  endtask

  task automatic rnd(bit v16, bit v32);
    cyc(v16, 16'($urandom), 16'($urandom), v32, $urandom, $urandom);
  endtask

  task automatic dir16(string name, logic [15:0] x, logic [15:0] y, longint exp);
    chk(name, m16(x, y), exp);
    cyc(1'b1, x, y, 1'b0, $urandom, $urandom);
  endtask

  // Per-cycle compare: out_valid must match the scheduled slot, AB the model or its held value.
  always @(negedge clk) begin
    bit e16, e32;
    e16 = (q16.size() > 0) && (q16[0].due == edge_cnt);
    e32 = (q32.size() > 0) && (q32[0].due == edge_cnt);
    chk("out_valid16", longint'(ov16), longint'(e16));
    chk("out_valid32", longint'(ov32), longint'(e32));
    if (e16) begin
      chk("ab16", longint'(ab16), q16[0].ab);
      last16 = q16[0].ab;
      void'(q16.pop_front());
    end else begin
      chk("ab16_hold", longint'(ab16), last16);
    end
    if (e32) begin
      chk("ab32", longint'(ab32), q32[0].ab);
      last32 = q32[0].ab;
      void'(q32.pop_front());
    end else begin
      chk("ab32_hold", longint'(ab32), last32);
    end
  end

  initial begin
    rst_n = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0;
    iv32 = 1'b0; a32 = '0; b32 = '0;
    #1;
    chk("reset_ov16", longint'(ov16), 0);
    chk("reset_ab16", longint'(ab16), 0);
    chk("reset_ov32", longint'(ov32), 0);
    chk("reset_ab32", longint'(ab32), 0);
    repeat (2) @(negedge clk);

    chk("pin_one16", m16(16'h0100, 16'h0100), 64'h0100);
    chk("pin_q16_2p5", m32(32'h0001_0000, 32'h0002_8000), 64'h0002_8000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'h0100, 16'h0100, 1'b1, 32'h0001_0000, 32'h0002_8000);

    dir16("pin_1p5x2", 16'h0180, 16'h0200, 64'h0300);
    dir16("pin_neg_half", 16'hFF00, 16'h0080, 64'hFF80);
    dir16("pin_trunc", 16'h0001, 16'h0001, 64'h0000);
    dir16("pin_floor", 16'hFFFF, 16'h0001, 64'hFFFF);
`ifdef MULTIPLIER_SATURATE_EN
    dir16("pin_ovf_pos", 16'h7F00, 16'h0200, 64'h7FFF);
    dir16("pin_ovf_neg", 16'h8000, 16'h0200, 64'h8000);
`else
    dir16("pin_ovf_pos", 16'h7F00, 16'h0200, 64'hFE00);
    dir16("pin_ovf_neg", 16'h8000, 16'h0200, 64'h0000);
`endif
    repeat (3) idle();

    // Streaming: 8 pairs, 2-cycle gap, 4 pairs on both widths.
    repeat (8) rnd(1'b1, 1'b1);
    repeat (2) idle();
    repeat (4) rnd(1'b1, 1'b1);
    repeat (4) idle();

    repeat (300) rnd($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

    // Reset with results in flight.
    rnd(1'b1, 1'b1);
    rnd(1'b1, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ov16", longint'(ov16), 0);
    chk("rst_mid_ab16", longint'(ab16), 0);
    chk("rst_mid_ov32", longint'(ov32), 0);
    chk("rst_mid_ab32", longint'(ab32), 0);
    q16.delete();
    q32.delete();
    last16 = 0;
    last32 = 0;
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'h0180, 16'h0200, 1'b1, 32'h0001_0000, 32'h0002_8000);
    repeat (8) idle();

    chk("drain16", longint'(q16.size()), 0);
    chk("drain32", longint'(q32.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
